lock_pin_responder: RTL and testbench

Command-side responder for the smart-lock UART link: consumes bytes delivered by the UART receiver and answers through the UART transmitter. Collects an ASCII PIN, checks it against a stored code on submit, drives the unlock output, enforces a lockout after repeated failures, and returns a one-byte status character to the host.

---
 rtl/lock_pin_responder_pkg.sv | 27 ++
 rtl/lock_pin_responder_timer.sv | 29 ++
 rtl/lock_pin_responder.sv | 142 ++++++++++++++
 tb/tb_lock_pin_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pin_responder_pkg.sv
// Shared constants for the smart-lock command responder: the ASCII bytes
// on the UART link and the responder FSM state encoding.
package lock_pin_responder_pkg;

  // Command bytes from the host
  localparam logic [7:0] CH_SUBMIT   = 8'h23;  // '#'
  localparam logic [7:0] CH_CLEAR    = 8'h2A;  // '*'
  localparam logic [7:0] CH_DIGIT_LO = 8'h30;  // '0'
  localparam logic [7:0] CH_DIGIT_HI = 8'h39;  // '9'

  // Status bytes returned to the host
  localparam logic [7:0] RSP_OK   = 8'h4F;  // 'O'
  localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'
  localparam logic [7:0] RSP_LOCK = 8'h4C;  // 'L'

  typedef enum logic [1:0] {
    ST_COLLECT   = 2'd0,
    ST_CHECK     = 2'd1,
    ST_SEND_REQ  = 2'd2,
    ST_SEND_WAIT = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_DIGIT_LO) && (b <= CH_DIGIT_HI);
  endfunction

endpackage

// File: rtl/lock_pin_responder_timer.sv
// Retriggerable pulse timer: a load makes active high for exactly CYCLES
// cycles starting the cycle after the load; a load while active restarts it.
module pulse_timer #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic active
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  // Count down from CYCLES to zero; active while non-zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/lock_pin_responder.sv
// Smart-lock command responder: collects an ASCII PIN from the UART
// receiver, checks it on '#', drives the unlock / lockout timers and
// answers with a one-byte status through the UART transmitter.
//
// Transmit handshake: start is high for the whole SEND_REQ state and
// data_tx is held from CHECK until the next CHECK. The transmitter
// acknowledges by dropping ready; the request is only considered taken
// once ready has been seen high and then low while start is asserted, so
// a transmitter still busy with an older byte cannot be mistaken for an
// acknowledge. The FSM then waits in SEND_WAIT for ready to return high.
module lock_pin_responder
  import lock_pin_responder_pkg::*;
#(
  parameter int          PIN_LEN       = 4,
  parameter logic [31:0] PIN_CODE      = 32'h0000_1234,
  parameter int          MAX_FAIL      = 3,
  parameter int          LOCK_CYCLES   = 1000,
  parameter int          UNLOCK_CYCLES = 500
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              rcv,
  input  logic [7:0]                        data_rx,
  input  logic                              ready,
  output logic                              start,
  output logic [7:0]                        data_tx,
  output logic                              unlock,
  output logic                              locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

  localparam int BW = 4 * PIN_LEN;            // digit buffer width
  localparam int CW = $clog2(PIN_LEN + 2);    // digit count, saturates at PIN_LEN+1
  localparam int FW = $clog2(MAX_FAIL + 1);   // failure counter width

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   fail_d;
  logic [7:0]      tx_d;
  logic            seen_q, seen_d;   // ready observed high during SEND_REQ
  logic            load_unlock, load_lock;
  logic [FW:0]     fail_inc;
  logic            pin_match;

  assign fail_inc  = {1'b0, fail_cnt} + (FW+1)'(1);
  assign pin_match = (cnt_q == CW'(PIN_LEN)) && (buf_q == PIN_CODE[BW-1:0]);
  assign start     = (state_q == ST_SEND_REQ);

  // State, digit buffer, response byte and failure counter registers
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q  <= ST_COLLECT;
      buf_q    <= '0;
      cnt_q    <= '0;
      fail_cnt <= '0;
      data_tx  <= 8'h00;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fail_cnt <= fail_d;
      data_tx  <= tx_d;
      seen_q   <= seen_d;
    end
  end

  // Next-state logic: PIN collection, verdict, transmit handshake
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    fail_d      = fail_cnt;
    tx_d        = data_tx;
    seen_d      = seen_q;
    load_unlock = 1'b0;
    load_lock   = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (rcv) begin
          if (is_digit(data_rx)) begin
            buf_d = (buf_q << 4) | BW'(data_rx[3:0]);
            // Saturating past PIN_LEN keeps an over-long entry a mismatch
            if (cnt_q != CW'(PIN_LEN + 1)) cnt_d = cnt_q + CW'(1);
          end else if (data_rx == CH_CLEAR) begin
            buf_d = '0;
            cnt_d = '0;
          end else if (data_rx == CH_SUBMIT) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        buf_d   = '0;
        cnt_d   = '0;
        seen_d  = 1'b0;
        state_d = ST_SEND_REQ;
        if (locked_out) begin
          tx_d = RSP_LOCK;
        end else if (pin_match) begin
          tx_d        = RSP_OK;
          fail_d      = '0;
          load_unlock = 1'b1;
        end else if (fail_inc == (FW+1)'(MAX_FAIL)) begin
          tx_d      = RSP_LOCK;
          fail_d    = '0;
          load_lock = 1'b1;
        end else begin
          tx_d   = RSP_ERR;
          fail_d = fail_inc[FW-1:0];
        end
      end
      ST_SEND_REQ: begin
        if (ready) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = ST_SEND_WAIT;
        end
      end
      ST_SEND_WAIT: begin
        if (ready) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  pulse_timer #(.CYCLES(UNLOCK_CYCLES)) u_unlock_timer (
    .clk    (clk),
    .rst    (rstn),
    .load   (load_unlock),
    .active (unlock)
  );

  pulse_timer #(.CYCLES(LOCK_CYCLES)) u_lock_timer (
    .clk    (clk),
    .rst    (rstn),
    .load   (load_lock),
    .active (locked_out)
  );

endmodule

// File: tb/tb_lock_pin_responder.sv
// Directed bench for lock_pin_responder: a table of PIN submissions with
// hand-computed responses, plus sequences for timer lengths, dropped bytes,
// late transmitter acknowledge and reset during a transmission.
module tb_lock_pin_responder;

  localparam int PIN_LEN       = 4;
  localparam int MAX_FAIL      = 3;
  localparam int LOCK_CYCLES   = 1000;
  localparam int UNLOCK_CYCLES = 500;

  localparam logic [7:0] R_OK   = 8'h4F;
  localparam logic [7:0] R_ERR  = 8'h45;
  localparam logic [7:0] R_LOCK = 8'h4C;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rcv;
  logic [7:0] data_rx;
  logic       ready;
  logic       start;
  logic [7:0] data_tx;
  logic       unlock;
  logic       locked_out;
  logic [1:0] fail_cnt;

  lock_pin_responder #(
    .PIN_LEN       (PIN_LEN),
    .PIN_CODE      (32'h0000_1234),
    .MAX_FAIL      (MAX_FAIL),
    .LOCK_CYCLES   (LOCK_CYCLES),
    .UNLOCK_CYCLES (UNLOCK_CYCLES)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rcv        (rcv),
    .data_rx    (data_rx),
    .ready      (ready),
    .start      (start),
    .data_tx    (data_tx),
    .unlock     (unlock),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse-length monitor: length of the most recent completed high pulse
  int unlock_run = 0, lock_run = 0;
  int last_unlock_len = 0, last_lock_len = 0;
  always @(negedge clk) begin
    if (rstn) begin
      unlock_run = 0;
      lock_run   = 0;
    end else begin
      if (unlock) unlock_run++;
      else if (unlock_run != 0) begin
        last_unlock_len = unlock_run;
        unlock_run = 0;
      end
      if (locked_out) lock_run++;
      else if (lock_run != 0) begin
        last_lock_len = lock_run;
        lock_run = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rcv = 1'b1;
    data_rx = b;
    tick();
    rcv = 1'b0;
  endtask

  task automatic send_str(input logic [63:0] s, input int len);
    for (int i = len - 1; i >= 0; i--) send_byte(s[8*i +: 8]);
  endtask

  // Submit a string ending in '#', check the response two cycles after the
  // '#' strobe, then acknowledge through a normal ready high-low-high cycle.
  task automatic do_txn(input string name, input logic [63:0] s, input int len,
                        input logic [7:0] rsp, input logic [1:0] fl,
                        input logic ul, input logic lk, output int rsp_cyc);
    send_str(s, len);
    tick();
    rsp_cyc = cyc;
    check({name, ".start"},      start,      1);
    check({name, ".data_tx"},    data_tx,    rsp);
    check({name, ".fail_cnt"},   fail_cnt,   fl);
    check({name, ".unlock"},     unlock,     ul);
    check({name, ".locked_out"}, locked_out, lk);
    tick();
    check({name, ".start_hold"}, start, 1);
    ready = 1'b0;
    tick();
    check({name, ".start_drop"}, start, 0);
    tick();
    ready = 1'b1;
    tick();
    check({name, ".data_held"}, data_tx, rsp);
  endtask

  task automatic wait_unlock_low(input int budget);
    int n = 0;
    while (unlock && n < budget) begin
      tick();
      n++;
    end
    check("unlock_expired", unlock, 0);
  endtask

  task automatic wait_lock_low(input int budget);
    int n = 0;
    while (locked_out && n < budget) begin
      tick();
      n++;
    end
    check("lock_expired", locked_out, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".start"},      start,      0);
    check({name, ".data_tx"},    data_tx,    8'h00);
    check({name, ".unlock"},     unlock,     0);
    check({name, ".locked_out"}, locked_out, 0);
    check({name, ".fail_cnt"},   fail_cnt,   0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] s;
    int          len;
    logic [7:0]  rsp;
    logic [1:0]  fl;
    logic        ul;
    logic        lk;
  } vec_t;

  vec_t vecs[8];
  int   row_cyc[8];

  initial begin
    int c;
    vecs[0] = '{"1235#",    5, R_ERR,  2'd1, 1'b0, 1'b0};
    vecs[1] = '{"12#",      3, R_ERR,  2'd2, 1'b0, 1'b0};
    vecs[2] = '{"12*1234#", 8, R_OK,   2'd0, 1'b1, 1'b0};
    vecs[3] = '{"1x2y34#",  7, R_OK,   2'd0, 1'b1, 1'b0};
    vecs[4] = '{"12345#",   6, R_ERR,  2'd1, 1'b1, 1'b0};
    vecs[5] = '{"#",        1, R_ERR,  2'd2, 1'b1, 1'b0};
    vecs[6] = '{"99#",      3, R_LOCK, 2'd0, 1'b1, 1'b1};
    vecs[7] = '{"1234#",    5, R_LOCK, 2'd0, 1'b1, 1'b1};

    rstn = 1'b1;
    rcv = 1'b0;
    data_rx = 8'h00;
    ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rstn = 1'b0;
    tick();

    // Correct PIN, unlock pulse length
    do_txn("ok_first", "1234#", 5, R_OK, 2'd0, 1'b1, 1'b0, c);
    wait_unlock_low(UNLOCK_CYCLES + 50);
    check("unlock_len", last_unlock_len, UNLOCK_CYCLES);

    // Table: errors, clear/ignored bytes, restart, lockout
    for (int i = 0; i < 8; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].s, vecs[i].len, vecs[i].rsp,
             vecs[i].fl, vecs[i].ul, vecs[i].lk, row_cyc[i]);
    end

    // The second 'O' restarted the unlock timer
    wait_unlock_low(UNLOCK_CYCLES + 50);
    check("unlock_restart_len", last_unlock_len,
          (row_cyc[3] - row_cyc[2]) + UNLOCK_CYCLES);

    // Correct PIN during lockout is refused and does not unlock
    check("still_locked", locked_out, 1);
    do_txn("ok_in_lockout", "1234#", 5, R_LOCK, 2'd0, 1'b0, 1'b1, c);
    wait_lock_low(LOCK_CYCLES + 50);
    check("lock_len", last_lock_len, LOCK_CYCLES);
    do_txn("ok_after_lock", "1234#", 5, R_OK, 2'd0, 1'b1, 1'b0, c);

    // Strobes during SEND_REQ / SEND_WAIT are dropped
    send_str("1234#", 5);
    tick();
    check("drop.start", start, 1);
    send_byte("9");
    ready = 1'b0;
    send_byte("9");
    send_byte("9");
    check("drop.start_drop", start, 0);
    ready = 1'b1;
    tick();
    do_txn("drop_then_ok", "1234#", 5, R_OK, 2'd0, 1'b1, 1'b0, c);

    // Transmitter busy on entry: low ready is not an acknowledge
    ready = 1'b0;
    send_str("1234#", 5);
    tick();
    check("busy.start", start, 1);
    check("busy.data_tx", data_tx, R_OK);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("busy.hold%0d", i), start, 1);
    end
    ready = 1'b1;
    tick();
    check("busy.hold_ready", start, 1);
    ready = 1'b0;
    tick();
    check("busy.start_drop", start, 0);
    ready = 1'b1;
    tick();

    // Reset in the middle of a transmission
    send_str("1235#", 5);
    tick();
    check("rst.start", start, 1);
    check("rst.data_tx", data_tx, R_ERR);
    check("rst.fail_cnt", fail_cnt, 1);
    #1;
    rstn = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    tick();
    rstn = 1'b0;
    tick();
    check_reset_outputs("rst_release");
    do_txn("ok_after_rst", "1234#", 5, R_OK, 2'd0, 1'b1, 1'b0, c);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
